// File: rtl/sweep_acq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
//  sweep_acq_pkg
//  Shared types and constants for the sweep acquisition sequencer.
//  Rev 1.0 - initial release
// ---------------------------------------------------------------------------
package sweep_acq_pkg;

  localparam int          C_DAC_WIDTH   = 10;
  localparam logic [15:0] C_PKG_TRAILER = 16'hA5A5;
  localparam logic [5:0]  C_HEADER_TAG  = 6'b101010;
  localparam logic [15:0] C_END_WORD    = 16'hFFFF;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_CFG_PULSE = 4'd2,
    S_WAIT_CFG  = 4'd3,
    S_HEADER    = 4'd4,
    S_ACQ       = 4'd5,
    S_NEXT      = 4'd6,
    S_END_MARK  = 4'd7,
    S_DONE      = 4'd8
  } seqState_t;

  // Per-step header word: tag in the upper bits, DAC value in the lower bits.
  function automatic logic [15:0] fmtHeader(input logic [5:0] tag,
                                            input logic [C_DAC_WIDTH-1:0] dac);
    return {tag, dac};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sweep_acq_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
//  sweep_acq_sequencer_if
//  Control, configuration-handshake and data signals of the sweep sequencer.
//  Rev 1.0 - initial release
// ---------------------------------------------------------------------------
interface sweep_acq_sequencer_if;
  import sweep_acq_pkg::*;

  logic                   SweepStart;
  logic                   SweepStop;
  logic [C_DAC_WIDTH-1:0] StartDAC;
  logic [C_DAC_WIDTH-1:0] EndDAC;
  logic [15:0]            MaxPackageNumber;
  logic [C_DAC_WIDTH-1:0] OutDAC0;
  logic                   LoadSCParameters;
  logic                   MicrorocConfigDone;
  logic                   SingleACQStart;
  logic [15:0]            ParallelData;
  logic                   ParallelData_en;
  logic                   UsbDataFifoFull;
  logic [15:0]            SweepACQData;
  logic                   SweepACQData_en;
  logic                   SweepTestDone;
  logic                   Overflow;

  // Sequencer side
  modport master (
    input  SweepStart, SweepStop, StartDAC, EndDAC, MaxPackageNumber,
           MicrorocConfigDone, ParallelData, ParallelData_en, UsbDataFifoFull,
    output OutDAC0, LoadSCParameters, SingleACQStart, SweepACQData,
           SweepACQData_en, SweepTestDone, Overflow
  );

  // Environment side (control source, config/ACQ logic, USB FIFO)
  modport slave (
    output SweepStart, SweepStop, StartDAC, EndDAC, MaxPackageNumber,
           MicrorocConfigDone, ParallelData, ParallelData_en, UsbDataFifoFull,
    input  OutDAC0, LoadSCParameters, SingleACQStart, SweepACQData,
           SweepACQData_en, SweepTestDone, Overflow
  );

endinterface
`default_nettype wire

// File: rtl/sweep_acq_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
//  sweep_acq_sequencer
//  Steps DAC0 from StartDAC to EndDAC; per step reloads slow control, writes
//  a header, forwards one acquisition of MaxPackageNumber packages to the USB
//  FIFO, and closes the sweep with an end word and a done pulse.
//  Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module sweep_acq_sequencer #(
  parameter int          DAC_WIDTH   = sweep_acq_pkg::C_DAC_WIDTH,
  parameter logic [15:0] PKG_TRAILER = sweep_acq_pkg::C_PKG_TRAILER,
  parameter logic [5:0]  HEADER_TAG  = sweep_acq_pkg::C_HEADER_TAG,
  parameter logic [15:0] END_WORD    = sweep_acq_pkg::C_END_WORD
) (
  input  wire logic             Clk,
  input  wire logic             reset,
  sweep_acq_sequencer_if.master bus
);
  import sweep_acq_pkg::*;

  seqState_t            r_state;
  seqState_t            w_nextState;

  logic [DAC_WIDTH-1:0] r_curDac;
  logic [DAC_WIDTH-1:0] r_outDac;
  logic [DAC_WIDTH-1:0] r_endDac;
  logic                 r_dirUp;
  logic [15:0]          r_maxPkg;
  logic [15:0]          r_pkgCnt;

  logic                 r_loadSc;
  logic                 r_acqStart;
  logic                 r_done;
  logic                 r_overflow;
  logic [15:0]          r_data;
  logic                 r_dataEn;

  logic                 w_abort;
  logic                 w_fwd;
  logic                 w_trailer;
  logic                 w_lastPkg;
  logic                 w_wrHeader;
  logic                 w_wrEnd;
  logic                 w_stepDac;

  // State register
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state decode and per-cycle action strobes
  always_comb begin
    w_nextState = r_state;
    w_wrHeader  = 1'b0;
    w_wrEnd     = 1'b0;
    w_stepDac   = 1'b0;
    // END_MARK/DONE are already terminating, so a stop there changes nothing.
    w_abort     = bus.SweepStop && (r_state != S_IDLE) &&
                  (r_state != S_END_MARK) && (r_state != S_DONE);
    // A word presented in the same cycle as a stop is still forwarded.
    w_fwd       = (r_state == S_ACQ) && bus.ParallelData_en;
    w_trailer   = w_fwd && (bus.ParallelData == PKG_TRAILER);
    w_lastPkg   = w_trailer && ((r_pkgCnt + 16'd1) == r_maxPkg);
    case (r_state)
      S_IDLE:      if (bus.SweepStart) w_nextState = S_LOAD;
      S_LOAD:      w_nextState = S_CFG_PULSE;
      S_CFG_PULSE: w_nextState = S_WAIT_CFG;
      S_WAIT_CFG:  if (bus.MicrorocConfigDone) w_nextState = S_HEADER;
      S_HEADER: begin
        if (!bus.UsbDataFifoFull) begin
          w_wrHeader  = 1'b1;
          w_nextState = (r_maxPkg == 16'd0) ? S_NEXT : S_ACQ;
        end
      end
      S_ACQ:       if (w_lastPkg) w_nextState = S_NEXT;
      S_NEXT: begin
        // Equality test before stepping keeps the DAC from wrapping.
        if (r_outDac == r_endDac) begin
          w_nextState = S_END_MARK;
        end else begin
          w_stepDac   = 1'b1;
          w_nextState = S_LOAD;
        end
      end
      S_END_MARK: begin
        if (!bus.UsbDataFifoFull) begin
          w_wrEnd     = 1'b1;
          w_nextState = S_DONE;
        end
      end
      S_DONE:      w_nextState = S_IDLE;
      default:     w_nextState = S_IDLE;
    endcase
    if (w_abort) begin
      w_nextState = S_END_MARK;
      w_wrHeader  = 1'b0;
      w_stepDac   = 1'b0;
    end
  end

  // Sweep parameters, DAC stepping, package counting and registered outputs
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_curDac   <= '0;
      r_outDac   <= '0;
      r_endDac   <= '0;
      r_dirUp    <= 1'b0;
      r_maxPkg   <= '0;
      r_pkgCnt   <= '0;
      r_loadSc   <= 1'b0;
      r_acqStart <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_data     <= '0;
      r_dataEn   <= 1'b0;
    end else begin
      r_loadSc   <= (r_state == S_CFG_PULSE);
      r_done     <= (r_state == S_DONE);
      r_acqStart <= (w_nextState == S_ACQ);
      r_dataEn   <= 1'b0;

      if ((r_state == S_IDLE) && bus.SweepStart) begin
        r_curDac   <= bus.StartDAC;
        r_endDac   <= bus.EndDAC;
        r_maxPkg   <= bus.MaxPackageNumber;
        r_dirUp    <= (bus.StartDAC <= bus.EndDAC);
        r_overflow <= 1'b0;
      end

      if (r_state == S_LOAD) r_outDac <= r_curDac;

      if (w_stepDac) begin
        r_curDac <= r_dirUp ? (r_outDac + DAC_WIDTH'(1)) : (r_outDac - DAC_WIDTH'(1));
      end

      // Header/end word and data are mutually exclusive by state.
      if (w_wrHeader) begin
        r_data   <= fmtHeader(HEADER_TAG, r_outDac);
        r_dataEn <= 1'b1;
      end else if (w_wrEnd) begin
        r_data   <= END_WORD;
        r_dataEn <= 1'b1;
      end else if (w_fwd) begin
        if (bus.UsbDataFifoFull) begin
          r_overflow <= 1'b1;
        end else begin
          r_data   <= bus.ParallelData;
          r_dataEn <= 1'b1;
        end
      end

      // Dropped trailers still count towards the package total.
      if ((r_state != S_ACQ) || w_lastPkg) r_pkgCnt <= '0;
      else if (w_trailer)                  r_pkgCnt <= r_pkgCnt + 16'd1;
    end
  end

  assign bus.OutDAC0          = r_outDac;
  assign bus.LoadSCParameters = r_loadSc;
  assign bus.SingleACQStart   = r_acqStart;
  assign bus.SweepACQData     = r_data;
  assign bus.SweepACQData_en  = r_dataEn;
  assign bus.SweepTestDone    = r_done;
  assign bus.Overflow         = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sweep_acq_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
//  tb_sweep_acq_sequencer
//  Self-checking bench: expected USB words queued as stimulus is issued,
//  compared by an independent monitor whenever the write strobe is seen.
//  Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_sweep_acq_sequencer;
  import sweep_acq_pkg::*;

  logic Clk = 1'b0;
  logic reset;
  always #5 Clk = ~Clk;

  sweep_acq_sequencer_if bus();

  sweep_acq_sequencer dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int          errors  = 0;
  int          checks  = 0;
  int          loadCnt = 0;
  int          doneCnt = 0;
  int          wrCnt   = 0;
  int          acqCnt  = 0;
  logic [15:0] expQ[$];
  logic [15:0] monExp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] randWord();
    logic [15:0] w;
    w = 16'($urandom);
    if (w == 16'hA5A5) w = 16'h1234;
    return w;
  endfunction

  // Scoreboard monitor and pulse counters, sampled mid-cycle
  always @(negedge Clk) begin
    if (!reset) begin
      if (bus.LoadSCParameters) loadCnt++;
      if (bus.SweepTestDone)    doneCnt++;
      if (bus.SingleACQStart)   acqCnt++;
      if (bus.SweepACQData_en) begin
        wrCnt++;
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL usb_write: got 0x%04h, expected no write", bus.SweepACQData);
        end else begin
          monExp = expQ.pop_front();
          if (bus.SweepACQData !== monExp) begin
            errors++;
            $display("FAIL usb_word: got 0x%04h, expected 0x%04h", bus.SweepACQData, monExp);
          end
        end
      end
    end
  end

  // One data-valid cycle; expected in the stream only if in ACQ and FIFO not full
  task automatic sendWord(input logic [15:0] w, input bit full, input bit stop, input bit fwd);
    bus.ParallelData    = w;
    bus.ParallelData_en = 1'b1;
    bus.UsbDataFifoFull = full;
    bus.SweepStop       = stop;
    if (fwd && !full) expQ.push_back(w);
    @(posedge Clk); #1;
    bus.ParallelData_en = 1'b0;
    bus.UsbDataFifoFull = 1'b0;
    bus.SweepStop       = 1'b0;
  endtask

  task automatic runSweep(input int s, input int e, input int m, input int abortStep,
                          input int resetStep, input bit fullAcq, input bit fullHdr);
    int dir, nSteps, dac, loads0, dones0, acq0, wr0, k, nJunk;
    bit stopped;
    dir     = (s <= e) ? 1 : -1;
    nSteps  = (s <= e) ? (e - s + 1) : (s - e + 1);
    loads0  = loadCnt;
    dones0  = doneCnt;
    acq0    = acqCnt;
    stopped = 1'b0;

    bus.StartDAC         = 10'(s);
    bus.EndDAC           = 10'(e);
    bus.MaxPackageNumber = 16'(m);
    bus.SweepStart       = 1'b1;
    @(posedge Clk); #1;
    bus.SweepStart = 1'b0;
    @(posedge Clk); #1;
    check("dac_at_start_plus2", bus.OutDAC0, s);
    check("load_not_early", bus.LoadSCParameters, 0);
    check("overflow_cleared", bus.Overflow, 0);
    @(posedge Clk); #1;
    check("load_at_start_plus3", bus.LoadSCParameters, 1);

    for (int st = 0; st < nSteps && !stopped; st++) begin
      dac = s + dir * st;
      if (st > 0) begin
        k = 0;
        while (!bus.LoadSCParameters && k < 60) begin @(posedge Clk); #1; k++; end
        check("load_pulse", bus.LoadSCParameters, 1);
        check("dac_step", bus.OutDAC0, dac);
      end
      repeat (4) @(posedge Clk);
      #1;
      bus.UsbDataFifoFull    = fullHdr && (st == 0);
      bus.MicrorocConfigDone = 1'b1;
      expQ.push_back(16'hA800 | 16'(dac));
      @(posedge Clk); #1;
      bus.MicrorocConfigDone = 1'b0;
      if (fullHdr && (st == 0)) begin
        wr0 = wrCnt;
        repeat (3) @(posedge Clk);
        #1;
        check("header_held_while_full", wrCnt - wr0, 0);
        bus.UsbDataFifoFull = 1'b0;
      end

      if (m > 0) begin
        k = 0;
        while (!bus.SingleACQStart && k < 60) begin @(posedge Clk); #1; k++; end
        check("acq_start", bus.SingleACQStart, 1);

        if (resetStep == st) begin
          sendWord(randWord(), 1'b0, 1'b0, 1'b1);
          repeat (2) @(posedge Clk);
          #1;
          check("drained_before_reset", expQ.size(), 0);
          #2 reset = 1'b1;
          #1;
          check("reset_outputs_mid_acq",
                {bus.OutDAC0, bus.LoadSCParameters, bus.SingleACQStart, bus.SweepACQData,
                 bus.SweepACQData_en, bus.SweepTestDone, bus.Overflow}, 0);
          @(posedge Clk); #1;
          reset = 1'b0;
          expQ.delete();
          return;
        end

        for (int p = 0; p < m && !stopped; p++) begin
          if (fullAcq && (st == 0) && (p == 0)) begin
            sendWord(randWord(), 1'b1, 1'b0, 1'b1);
            sendWord(randWord(), 1'b1, 1'b0, 1'b1);
            sendWord(16'hA5A5,   1'b1, 1'b0, 1'b1);
            check("overflow_set", bus.Overflow, 1);
          end else begin
            nJunk = $urandom_range(0, 2);
            for (int j = 0; j < nJunk; j++) sendWord(randWord(), 1'b0, 1'b0, 1'b1);
            if (abortStep == st) begin
              sendWord(16'hA5A5, 1'b0, 1'b1, 1'b1);
              check("acq_drop_on_stop", bus.SingleACQStart, 0);
              stopped = 1'b1;
            end else begin
              sendWord(16'hA5A5, 1'b0, 1'b0, 1'b1);
            end
          end
          if (!stopped) begin
            if (p == m - 1) begin
              check("acq_drop_after_last", bus.SingleACQStart, 0);
              sendWord(randWord(), 1'b0, 1'b0, 1'b0);
            end else begin
              check("acq_held", bus.SingleACQStart, 1);
            end
          end
        end
      end
    end

    expQ.push_back(16'hFFFF);
    k = 0;
    while ((doneCnt == dones0) && k < 100) begin @(posedge Clk); #1; k++; end
    repeat (3) @(posedge Clk);
    #1;
    check("done_pulses", doneCnt - dones0, 1);
    check("load_pulses", loadCnt - loads0, stopped ? (abortStep + 1) : nSteps);
    check("stream_drained", expQ.size(), 0);
    if (!stopped) check("final_dac", bus.OutDAC0, e);
    if (m == 0)   check("acq_never_asserted", acqCnt - acq0, 0);
    if (fullAcq)  check("overflow_sticky", bus.Overflow, 1);
  endtask

  initial begin
    int s, e, m;
    bus.SweepStart         = 1'b0;
    bus.SweepStop          = 1'b0;
    bus.StartDAC           = '0;
    bus.EndDAC             = '0;
    bus.MaxPackageNumber   = '0;
    bus.MicrorocConfigDone = 1'b0;
    bus.ParallelData       = '0;
    bus.ParallelData_en    = 1'b0;
    bus.UsbDataFifoFull    = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("reset_outputs",
          {bus.OutDAC0, bus.LoadSCParameters, bus.SingleACQStart, bus.SweepACQData,
           bus.SweepACQData_en, bus.SweepTestDone, bus.Overflow}, 0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    reset = 1'b0;

    runSweep(5, 7, 2, -1, -1, 1'b0, 1'b0);
    runSweep(3, 1, 1, -1, -1, 1'b0, 1'b0);
    runSweep(1023, 1023, 0, -1, -1, 1'b0, 1'b1);
    runSweep(20, 22, 2, -1, -1, 1'b1, 1'b0);
    runSweep(10, 14, 3, 1, -1, 1'b0, 1'b0);
    runSweep(40, 43, 2, -1, 1, 1'b0, 1'b0);
    runSweep(40, 41, 1, -1, -1, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      s = $urandom_range(2, 1020);
      e = s + $urandom_range(0, 4) - 2;
      m = $urandom_range(0, 3);
      runSweep(s, e, m, -1, -1, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
